naneye_tx_encoder: RTL and testbench

// Sensor-side serial encoder for the NanEye pixel link. It takes parallel pixel words
// and emits them on the same 1-wire Manchester stream the receive path decodes,

---
 rtl/naneye_tx_encoder.sv | 198 +++++++++++++++++++
 tb/tb_naneye_tx_encoder.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/naneye_tx_encoder.sv
// naneye_tx_encoder
// Sensor-side serial encoder for the NanEye pixel link. Parallel pixel words are
// framed as {start '1', data MSB..LSB, stop '0'} and sent Manchester coded on a
// single wire (half 1 = bit, half 2 = ~bit). Lines are separated by LINE_IDLE_BITS
// of low line, frames are preceded by FRAME_IDLE_BITS of low line.
//
// Ports
//   CLOCK            single clock
//   RESET            asynchronous reset, active-high
//   FRAME_START_REQ  one-cycle request for one frame; dropped while TX_BUSY=1
//   PIX_DATA         pixel word, qualified by PIX_VALID
//   PIX_VALID        PIX_DATA available
//   PIX_READY        word consumed this cycle if PIX_VALID=1 (load point)
//   TX_OUT           registered Manchester line output
//   TX_BUSY          high whenever a frame is in progress
//   LINE_DONE        one-cycle pulse after the last half-bit of a line
//   FRAME_DONE       one-cycle pulse after the last half-bit of the last line
//   UNDERRUN         one-cycle pulse when a word was due and PIX_VALID=0
module naneye_tx_encoder #(
   parameter int D_WIDTH         = 10,
   parameter int PIXELS_PER_LINE = 320,
   parameter int ROWS            = 320,
   parameter int HALF_BIT_CLKS   = 4,
   parameter int LINE_IDLE_BITS  = 9,
   parameter int FRAME_IDLE_BITS = 64
) (
   input  logic               CLOCK,
   input  logic               RESET,
   input  logic               FRAME_START_REQ,
   input  logic [D_WIDTH-1:0] PIX_DATA,
   input  logic               PIX_VALID,
   output logic               PIX_READY,
   output logic               TX_OUT,
   output logic               TX_BUSY,
   output logic               LINE_DONE,
   output logic               FRAME_DONE,
   output logic               UNDERRUN
);

   localparam int WORD_BITS      = D_WIDTH + 2;
   localparam int LAST_HALF      = 2 * WORD_BITS - 1;
   localparam int FRAME_GAP_CLKS = FRAME_IDLE_BITS * 2 * HALF_BIT_CLKS;
   localparam int LINE_GAP_CLKS  = LINE_IDLE_BITS * 2 * HALF_BIT_CLKS;
   localparam int GAP_MAX        = (FRAME_GAP_CLKS > LINE_GAP_CLKS) ? FRAME_GAP_CLKS : LINE_GAP_CLKS;

   // Counter widths follow $clog2(max+1), kept at least one bit wide.
   localparam int HALF_W = (HALF_BIT_CLKS > 1) ? $clog2(HALF_BIT_CLKS) : 1;
   localparam int BIT_W  = $clog2(LAST_HALF + 1);
   localparam int PIX_W  = (PIXELS_PER_LINE > 1) ? $clog2(PIXELS_PER_LINE) : 1;
   localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int GAP_W  = (GAP_MAX > 1) ? $clog2(GAP_MAX) : 1;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      FRAME_GAP = 2'd1,
      PIXEL     = 2'd2,
      LINE_GAP  = 2'd3
   } state_t;

   state_t state;
   state_t state_next;

   logic [HALF_W-1:0]    half_cnt;
   logic [BIT_W-1:0]     bit_idx;    // half-bit index within the word
   logic [PIX_W-1:0]     pix_cnt;
   logic [ROW_W-1:0]     row_cnt;
   logic [GAP_W-1:0]     gap_cnt;
   logic [WORD_BITS-1:0] shreg_p0;   // bit on the line sits in the MSB
   logic [D_WIDTH-1:0]   load_data;
   logic                 tx_q;
   logic                 tx_next;
   logic                 line_done_q;
   logic                 frame_done_q;

   logic half_end;
   logic word_end;
   logic last_pix;
   logic last_row;
   logic gap_end;
   logic line_end;
   logic load;

   assign half_end = (half_cnt == HALF_W'(HALF_BIT_CLKS - 1));
   assign word_end = half_end && (bit_idx == BIT_W'(LAST_HALF));
   assign last_pix = (pix_cnt == PIX_W'(PIXELS_PER_LINE - 1));
   assign last_row = (row_cnt == ROW_W'(ROWS - 1));
   assign gap_end  = ((state == FRAME_GAP) && (gap_cnt == GAP_W'(FRAME_GAP_CLKS - 1))) ||
                     ((state == LINE_GAP)  && (gap_cnt == GAP_W'(LINE_GAP_CLKS - 1)));
   assign line_end = (state == PIXEL) && word_end && last_pix;
   // Load point: last gap cycle, or last cycle of a word that is not the last of its line.
   assign load     = gap_end || ((state == PIXEL) && word_end && !last_pix);

   // A missing word is replaced by zeros so line timing never stretches.
   assign load_data = PIX_VALID ? PIX_DATA : '0;

   // State register
   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         IDLE:      if (FRAME_START_REQ) state_next = FRAME_GAP;
         FRAME_GAP: if (gap_end)         state_next = PIXEL;
         PIXEL:     if (line_end)        state_next = last_row ? IDLE : LINE_GAP;
         LINE_GAP:  if (gap_end)         state_next = PIXEL;
         default:                        state_next = IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      PIX_READY = load;
      UNDERRUN  = load && !PIX_VALID;
      TX_BUSY   = (state != IDLE);
   end

   // Next line value: the start half of a new word at a load point, otherwise
   // hold within a half-bit and switch to the next half at its boundary.
   always_comb begin
      tx_next = 1'b0;
      if (load) begin
         tx_next = 1'b1;
      end else if (state == PIXEL) begin
         if (!half_end) begin
            tx_next = tx_q;
         end else if (word_end) begin
            tx_next = 1'b0;
         end else if (!bit_idx[0]) begin
            tx_next = ~shreg_p0[WORD_BITS-1];
         end else begin
            tx_next = shreg_p0[WORD_BITS-2];
         end
      end
   end

   // Control stage: counters and registered outputs
   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         half_cnt     <= '0;
         bit_idx      <= '0;
         pix_cnt      <= '0;
         row_cnt      <= '0;
         gap_cnt      <= '0;
         tx_q         <= 1'b0;
         line_done_q  <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         tx_q         <= tx_next;
         line_done_q  <= line_end;
         frame_done_q <= line_end && last_row;

         if ((state == FRAME_GAP) || (state == LINE_GAP)) begin
            gap_cnt <= gap_end ? '0 : gap_cnt + 1'b1;
         end else begin
            gap_cnt <= '0;
         end

         if (state == PIXEL) begin
            half_cnt <= half_end ? '0 : half_cnt + 1'b1;
            if (half_end) begin
               bit_idx <= (bit_idx == BIT_W'(LAST_HALF)) ? '0 : bit_idx + 1'b1;
            end
         end else begin
            half_cnt <= '0;
            bit_idx  <= '0;
         end

         if ((state == PIXEL) && word_end) begin
            pix_cnt <= last_pix ? '0 : pix_cnt + 1'b1;
         end

         if (line_end) begin
            row_cnt <= last_row ? '0 : row_cnt + 1'b1;
         end
      end
   end

   // Data stage: word shift register, shifted once per completed bit
   always_ff @(posedge CLOCK) begin
      if (load) begin
         shreg_p0 <= {1'b1, load_data, 1'b0};
      end else if ((state == PIXEL) && half_end && bit_idx[0]) begin
         shreg_p0 <= {shreg_p0[WORD_BITS-2:0], 1'b0};
      end
   end

   assign TX_OUT     = tx_q;
   assign LINE_DONE  = line_done_q;
   assign FRAME_DONE = frame_done_q;

endmodule

// File: tb/tb_naneye_tx_encoder.sv
// Bench for naneye_tx_encoder with a small geometry: 3 pixels per line, 2 rows,
// 2 clocks per half-bit, 4 frame idle bits, 9 line idle bits. A timing model
// derived from frame arithmetic predicts every output each cycle; a few fixed
// cycle numbers and one literal Manchester pattern pin the model.
module tb_naneye_tx_encoder;

   localparam int DW  = 10;
   localparam int PPL = 3;
   localparam int NR  = 2;
   localparam int H   = 2;
   localparam int LIB = 9;
   localparam int FIB = 4;

   localparam int WORD  = 2 * (DW + 2) * H;      // 48
   localparam int LINE  = PPL * WORD;            // 144
   localparam int FG    = FIB * 2 * H;           // 16
   localparam int LG    = LIB * 2 * H;           // 36
   localparam int TOTAL = FG + NR * LINE + (NR - 1) * LG;  // 340
   localparam int TRN   = 8192;

   logic          CLOCK = 1'b0;
   logic          RESET;
   logic          FRAME_START_REQ;
   logic [DW-1:0] PIX_DATA;
   logic          PIX_VALID;
   logic          PIX_READY, TX_OUT, TX_BUSY, LINE_DONE, FRAME_DONE, UNDERRUN;

   naneye_tx_encoder #(
      .D_WIDTH(DW), .PIXELS_PER_LINE(PPL), .ROWS(NR), .HALF_BIT_CLKS(H),
      .LINE_IDLE_BITS(LIB), .FRAME_IDLE_BITS(FIB)
   ) dut (
      .CLOCK(CLOCK), .RESET(RESET), .FRAME_START_REQ(FRAME_START_REQ),
      .PIX_DATA(PIX_DATA), .PIX_VALID(PIX_VALID), .PIX_READY(PIX_READY),
      .TX_OUT(TX_OUT), .TX_BUSY(TX_BUSY), .LINE_DONE(LINE_DONE),
      .FRAME_DONE(FRAME_DONE), .UNDERRUN(UNDERRUN)
   );

   always #5 CLOCK = ~CLOCK;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   always @(posedge CLOCK) cyc <= cyc + 1;

   logic tr_tx [TRN], tr_ld [TRN], tr_fd [TRN], tr_rdy [TRN], tr_und [TRN];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 40)
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic          m_active = 1'b0;
   int            m_start  = 0;
   logic [DW-1:0] m_words [PPL*NR];

   logic e_tx, e_busy, e_rdy, e_ld, e_fd;
   int   o, q, r, p, w, hc, hb, idx;
   logic [DW+1:0] wbits;

   always @(negedge CLOCK) begin
      e_tx = 0; e_busy = 0; e_rdy = 0; e_ld = 0; e_fd = 0; idx = -1;
      if (RESET) begin
         m_active = 1'b0;
      end else if (m_active) begin
         o = cyc - m_start;
         if (o < TOTAL) begin
            e_busy = 1;
            if (o < FG) begin
               if (o == FG - 1) begin e_rdy = 1; idx = 0; end
            end else begin
               q = o - FG;
               r = q / (LINE + LG);
               p = q % (LINE + LG);
               if (p < LINE) begin
                  w     = p / WORD;
                  hc    = p % WORD;
                  hb    = hc / H;
                  wbits = {1'b1, m_words[r*PPL + w], 1'b0};
                  e_tx  = (hb % 2 == 0) ? wbits[DW+1 - hb/2] : ~wbits[DW+1 - hb/2];
                  if (hc == WORD - 1 && w < PPL - 1) begin e_rdy = 1; idx = r*PPL + w + 1; end
               end else begin
                  if (p == LINE) e_ld = 1;
                  if (p == LINE + LG - 1) begin e_rdy = 1; idx = (r + 1) * PPL; end
               end
            end
         end else begin
            e_ld = 1; e_fd = 1;
            m_active = 1'b0;
         end
      end

      chk("tx_out",     TX_OUT,     e_tx);
      chk("tx_busy",    TX_BUSY,    e_busy);
      chk("pix_ready",  PIX_READY,  e_rdy);
      chk("line_done",  LINE_DONE,  e_ld);
      chk("frame_done", FRAME_DONE, e_fd);
      chk("underrun",   UNDERRUN,   e_rdy & ~PIX_VALID);

      if (idx >= 0) m_words[idx] = PIX_VALID ? PIX_DATA : '0;
      if (!RESET && FRAME_START_REQ && !e_busy) begin
         m_active = 1'b1;
         m_start  = cyc + 1;
      end

      if (cyc < TRN) begin
         tr_tx[cyc] = TX_OUT; tr_ld[cyc] = LINE_DONE; tr_fd[cyc] = FRAME_DONE;
         tr_rdy[cyc] = PIX_READY; tr_und[cyc] = UNDERRUN;
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge CLOCK);
      #1;
   endtask

   function automatic int count(input int kind, input int a, input int b);
      int n = 0;
      for (int i = a; i <= b; i++) begin
         if (kind == 0 && tr_fd[i])  n++;
         if (kind == 1 && tr_rdy[i]) n++;
         if (kind == 2 && tr_und[i]) n++;
      end
      return n;
   endfunction

   int R1, R2, R3, R4;
   logic [23:0] halves;

   initial begin
      RESET = 1'b1; FRAME_START_REQ = 1'b0; PIX_VALID = 1'b0; PIX_DATA = '0;
      repeat (4) tick();
      RESET = 1'b0;
      repeat (6) tick();

      // Frames 1 and 2: fixed 0x2AA data, an ignored mid-frame request, a
      // back-to-back request in the FRAME_DONE cycle, underrun at the second load.
      R1 = cyc; R2 = R1 + TOTAL + 1;
      FRAME_START_REQ = 1'b1; PIX_VALID = 1'b1; PIX_DATA = 10'h2AA;
      while (cyc < R2 + TOTAL + 10) begin
         tick();
         FRAME_START_REQ = (cyc == R1 + 100) || (cyc == R2);
         if (cyc > R2) begin
            PIX_DATA  = DW'($urandom);
            PIX_VALID = (cyc != R2 + FG + WORD);
         end
      end

      // Random traffic
      repeat (2000) begin
         tick();
         FRAME_START_REQ = ($urandom_range(0, 39) == 0);
         PIX_VALID       = ($urandom_range(0, 7) != 0);
         PIX_DATA        = DW'($urandom);
      end
      FRAME_START_REQ = 1'b0;
      repeat (TOTAL + 20) tick();

      // Reset during bit 5 of the first word
      R3 = cyc; FRAME_START_REQ = 1'b1; PIX_VALID = 1'b1;
      while (cyc < R3 + FG + 1 + 10 * H + 1) begin
         tick();
         FRAME_START_REQ = 1'b0;
         PIX_DATA = DW'($urandom);
      end
      chk("busy_before_reset", TX_BUSY, 1);
      RESET = 1'b1;
      #1;
      chk("tx_after_reset",   TX_OUT,  0);
      chk("busy_after_reset", TX_BUSY, 0);
      repeat (3) tick();
      RESET = 1'b0;
      repeat (4) tick();

      R4 = cyc; FRAME_START_REQ = 1'b1;
      while (cyc < R4 + TOTAL + 10) begin
         tick();
         FRAME_START_REQ = 1'b0;
         PIX_VALID = ($urandom_range(0, 3) != 0);
         PIX_DATA  = DW'($urandom);
      end

      // Literal expectations from hand arithmetic
      halves = 24'b101001100110011001100101;  // Manchester of 1_1010101010_0
      chk("f1_gap_low",  tr_tx[R1 + 16], 0);
      chk("f1_first_hi", tr_tx[R1 + 17], 1);
      for (int i = 0; i < WORD; i++) chk("f1_word0", tr_tx[R1 + 17 + i], halves[23 - i/2]);
      chk("f1_ld_early", tr_ld[R1 + 160], 0);
      chk("f1_ld",       tr_ld[R1 + 161], 1);
      chk("f1_fd_row0",  tr_fd[R1 + 161], 0);
      for (int i = 0; i < LG; i++) chk("f1_line_gap", tr_tx[R1 + 161 + i], 0);
      chk("f1_row1_start", tr_tx[R1 + 197], 1);
      chk("f1_fd",       tr_fd[R1 + 341], 1);
      chk("f1_ld_last",  tr_ld[R1 + 341], 1);
      chk("f1_fd_count", count(0, R1 + 1, R1 + 341), 1);
      chk("f2_gap_low",  tr_tx[R2 + 16], 0);
      chk("f2_first_hi", tr_tx[R2 + 17], 1);
      chk("f2_underrun", tr_und[R2 + 64], 1);
      chk("f2_und_count", count(2, R2 + 1, R2 + 341), 1);
      chk("f2_rdy_count", count(1, R2 + 1, R2 + 341), PPL * NR);
      chk("f2_fd",       tr_fd[R2 + 341], 1);
      chk("f4_first_hi", tr_tx[R4 + 17], 1);
      chk("f4_fd",       tr_fd[R4 + 341], 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
